// File: rtl/sba_mem_arbiter.sv
// Shares one req/gnt/r_valid memory master port between NUM_REQ requesters, one transaction
// in flight. Define MEM_ARB_RR_EN for round-robin; otherwise fixed priority (index 0 highest).
module sba_mem_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       addr_i,
    input  logic [NUM_REQ-1:0]                  we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       wdata_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   be_i,
    output logic [NUM_REQ-1:0]                  gnt_o,
    output logic [NUM_REQ-1:0]                  r_valid_o,
    output logic [DATA_WIDTH-1:0]               r_rdata_o,
    output logic                                mem_req_o,
    output logic [ADDR_WIDTH-1:0]               mem_addr_o,
    output logic                                mem_we_o,
    output logic [DATA_WIDTH-1:0]               mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]             mem_be_o,
    input  logic                                mem_gnt_i,
    input  logic                                mem_r_valid_i,
    input  logic [DATA_WIDTH-1:0]               mem_r_rdata_i,
    output logic                                busy_o
);

    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_t;

    state_t                 r_state, w_state_next;
    logic [IDX_WIDTH-1:0]   r_owner;
    logic [IDX_WIDTH-1:0]   w_winner;
    logic                   w_any_req;
    logic [NUM_REQ-1:0]     w_owner_oh;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [NUM_REQ-1:0]     w_rvalid;

    logic                   r_mem_req;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic                   r_mem_we;
    logic [DATA_WIDTH-1:0]  r_mem_wdata;
    logic [BE_WIDTH-1:0]    r_mem_be;

    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic                   w_sel_we;
    logic [DATA_WIDTH-1:0]  w_sel_wdata;
    logic [BE_WIDTH-1:0]    w_sel_be;

    assign w_any_req = |req_i;

`ifdef MEM_ARB_RR_EN
    logic [IDX_WIDTH-1:0] r_last_winner;
    logic [IDX_WIDTH-1:0] w_hi_idx, w_lo_idx;
    logic                 w_hi_found, w_lo_found;

    // Requesters above the last winner take precedence; otherwise wrap to the lowest one.
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_i[i]) begin
                if (IDX_WIDTH'(i) > r_last_winner) begin
                    if (!w_hi_found) begin
                        w_hi_idx   = IDX_WIDTH'(i);
                        w_hi_found = 1'b1;
                    end
                end else if (!w_lo_found) begin
                    w_lo_idx   = IDX_WIDTH'(i);
                    w_lo_found = 1'b1;
                end
            end
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_winner <= IDX_WIDTH'(NUM_REQ - 1);
        end else if (r_state == StReq && mem_gnt_i) begin
            r_last_winner <= r_owner;
        end
    end
`else
    logic w_found;

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_i[i] && !w_found) begin
                w_winner = IDX_WIDTH'(i);
                w_found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDX_WIDTH'(i)) begin
                w_sel_addr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_we    = we_i[i];
                w_sel_wdata = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_be    = be_i[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    always_comb begin
        w_state_next = r_state;
        w_gnt        = '0;
        w_rvalid     = '0;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) w_state_next = StReq;
            end
            StReq: begin
                if (mem_gnt_i) begin
                    w_gnt = w_owner_oh;
                    if (mem_r_valid_i) begin
                        w_rvalid     = w_owner_oh;
                        w_state_next = StIdle;
                    end else begin
                        w_state_next = StRsp;
                    end
                end
            end
            StRsp: begin
                if (mem_r_valid_i) begin
                    w_rvalid     = w_owner_oh;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Payload is captured once in IDLE and held frozen until the next arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_owner     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && w_any_req) begin
                r_owner     <= w_winner;
                r_mem_req   <= 1'b1;
                r_mem_addr  <= w_sel_addr;
                r_mem_we    <= w_sel_we;
                r_mem_wdata <= w_sel_wdata;
                r_mem_be    <= w_sel_be;
            end else if (r_state == StReq && mem_gnt_i) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    assign gnt_o       = w_gnt;
    assign r_valid_o   = w_rvalid;
    assign r_rdata_o   = mem_r_rdata_i;
    assign mem_req_o   = r_mem_req;
    assign mem_addr_o  = r_mem_addr;
    assign mem_we_o    = r_mem_we;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_be_o    = r_mem_be;
    assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_sba_mem_arbiter.sv
// Self-checking bench for sba_mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_sba_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = DW / 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_i = '0;
    logic [N*AW-1:0] addr_i = '0;
    logic [N-1:0]    we_i = '0;
    logic [N*DW-1:0] wdata_i = '0;
    logic [N*BW-1:0] be_i = '0;
    logic [N-1:0]    gnt_o, r_valid_o;
    logic [DW-1:0]   r_rdata_o;
    logic            mem_req_o, mem_we_o, busy_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [BW-1:0]   mem_be_o;
    logic            mem_gnt_i = 1'b0;
    logic            mem_r_valid_i = 1'b0;
    logic [DW-1:0]   mem_r_rdata_i = '0;

    int n_checks = 0;
    int n_fail   = 0;

    sba_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .wdata_i       (wdata_i),
        .be_i          (be_i),
        .gnt_o         (gnt_o),
        .r_valid_o     (r_valid_o),
        .r_rdata_o     (r_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_be_o      (mem_be_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_r_valid_i (mem_r_valid_i),
        .mem_r_rdata_i (mem_r_rdata_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: at most one latched transaction, granted or not yet.
    bit            m_busy, m_granted;
    int            m_owner, m_last;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;

    function automatic int pick(input logic [N-1:0] r, input int last);
        if (RR) begin
            for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
        end else begin
            for (int i = 0; i < N; i++) if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_granted = 0; m_owner = 0; m_last = N - 1;
        m_addr = '0; m_we = 1'b0; m_wdata = '0; m_be = '0;
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (req_i != '0) begin
                m_owner   = pick(req_i, m_last);
                m_busy    = 1;
                m_granted = 0;
                m_addr    = addr_i[m_owner*AW +: AW];
                m_we      = we_i[m_owner];
                m_wdata   = wdata_i[m_owner*DW +: DW];
                m_be      = be_i[m_owner*BW +: BW];
            end
        end else if (!m_granted) begin
            if (mem_gnt_i) begin
                m_last = m_owner;
                if (mem_r_valid_i) m_busy = 0;
                else m_granted = 1;
            end
        end else if (mem_r_valid_i) begin
            m_busy = 0;
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] e_gnt, e_rv;
        if (!rst_n) model_reset();
        e_gnt = (m_busy && !m_granted && mem_gnt_i) ? (N'(1) << m_owner) : '0;
        e_rv  = (m_busy && (m_granted || mem_gnt_i) && mem_r_valid_i) ? (N'(1) << m_owner) : '0;
        chk("gnt_o", gnt_o, e_gnt);
        chk("r_valid_o", r_valid_o, e_rv);
        chk("mem_req_o", mem_req_o, m_busy && !m_granted);
        chk("busy_o", busy_o, m_busy);
        chk("mem_addr_o", mem_addr_o, m_addr);
        chk("mem_we_o", mem_we_o, m_we);
        chk("mem_wdata_o", mem_wdata_o, m_wdata);
        chk("mem_be_o", mem_be_o, m_be);
        if (e_rv != '0) chk("r_rdata_o", r_rdata_o, mem_r_rdata_i);
        if (rst_n) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pl(input int i, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
        addr_i[i*AW +: AW]  = a;
        we_i[i]             = w;
        wdata_i[i*DW +: DW] = d;
        be_i[i*BW +: BW]    = b;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int            n, win;
        bit            pending;
        logic [N-1:0]  last_gnt;

        // Reset
        tick(); tick();
        #3;
        chk("reset_busy", busy_o, 0);
        chk("reset_mem_req", mem_req_o, 0);
        chk("reset_mem_addr", mem_addr_o, 0);
        tick();
        rst_n = 1'b1;

        // Single read: cycle 0 request, grant at 1, response at 4
        tick();
        set_pl(0, 32'h1000, 1'b0, '0, 8'hFF);
        req_i = 3'b001;
        tick();
        mem_gnt_i = 1'b1;
        #3;
        chk("read_gnt", gnt_o, 3'b001);
        chk("read_mem_addr", mem_addr_o, 32'h1000);
        tick();
        mem_gnt_i = 1'b0;
        req_i = '0;
        tick();
        tick();
        mem_r_valid_i = 1'b1;
        mem_r_rdata_i = 64'hDEADBEEF;
        #3;
        chk("read_rvalid", r_valid_o, 3'b001);
        chk("read_rdata", r_rdata_o, 64'hDEADBEEF);
        tick();
        mem_r_valid_i = 1'b0;
        #3;
        chk("read_idle_after", busy_o, 0);

        // Contention: two requesters held, response 2 cycles after each grant
        tick();
        set_pl(0, 32'h0100, 1'b0, '0, 8'h01);
        set_pl(1, 32'h0200, 1'b0, '0, 8'h02);
        req_i = 3'b011;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!mem_req_o && n < 8) begin
                tick();
                n++;
            end
            chk("contention_req_seen", mem_req_o, 1);
            mem_gnt_i = 1'b1;
            #3;
            win = (gnt_o == 3'b001) ? 0 : (gnt_o == 3'b010) ? 1 : -1;
            chk($sformatf("contention_grant_%0d", k), win, RR ? (k % 2) : 0);
            tick();
            mem_gnt_i = 1'b0;
            tick();
            mem_r_valid_i = 1'b1;
            mem_r_rdata_i = {$urandom, $urandom};
            tick();
            mem_r_valid_i = 1'b0;
            if (k == 3) req_i = '0;
        end
        tick();

        // Grant stall with requester 1 dropping and changing payload
        set_pl(1, 32'hA5A5_0000, 1'b1, 64'h1111_2222_3333_4444, 8'h0F);
        req_i = 3'b010;
        tick();
        for (int s = 0; s < 5; s++) begin
            if (s == 0) req_i = '0;
            if (s == 2) begin
                set_pl(1, 32'h5A5A_FFFF, 1'b0, 64'h9999_8888_7777_6666, 8'hF0);
                req_i = 3'b010;
            end
            #3;
            chk("stall_addr", mem_addr_o, 32'hA5A5_0000);
            chk("stall_wdata", mem_wdata_o, 64'h1111_2222_3333_4444);
            chk("stall_no_gnt", gnt_o, 3'b000);
            tick();
        end
        mem_gnt_i = 1'b1;
        #3;
        chk("stall_gnt", gnt_o, 3'b010);
        tick();
        mem_gnt_i = 1'b0;
        req_i = '0;
        mem_r_valid_i = 1'b1;
        #3;
        chk("stall_rvalid", r_valid_o, 3'b010);
        tick();
        mem_r_valid_i = 1'b0;

        // Grant and response in the same cycle
        set_pl(0, 32'h2000, 1'b1, 64'hCAFE_F00D_0000_0001, 8'hFF);
        req_i = 3'b001;
        tick();
        mem_gnt_i = 1'b1;
        mem_r_valid_i = 1'b1;
        #3;
        chk("same_gnt", gnt_o, 3'b001);
        chk("same_rvalid", r_valid_o, 3'b001);
        chk("same_we", mem_we_o, 1);
        chk("same_be", mem_be_o, 8'hFF);
        tick();
        mem_gnt_i = 1'b0;
        mem_r_valid_i = 1'b0;
        req_i = '0;
        #3;
        chk("same_idle_next", busy_o, 0);
        tick();

        // Reset while waiting for the response, then a stray response
        set_pl(2, 32'h3000, 1'b0, 64'h55, 8'h0F);
        req_i = 3'b100;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        req_i = '0;
        rst_n = 1'b0;
        #3;
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        tick();
        rst_n = 1'b1;
        mem_r_valid_i = 1'b1;
        #3;
        chk("stray_rvalid", r_valid_o, 0);
        chk("stray_mem_be", mem_be_o, 0);
        chk("stray_mem_wdata", mem_wdata_o, 0);
        tick();
        mem_r_valid_i = 1'b0;
        set_pl(1, 32'h4000, 1'b0, '0, 8'h3C);
        req_i = 3'b010;
        tick();
        mem_gnt_i = 1'b1;
        #3;
        chk("post_rst_req", mem_req_o, 1);
        chk("post_rst_addr", mem_addr_o, 32'h4000);
        chk("post_rst_gnt", gnt_o, 3'b010);
        tick();
        mem_gnt_i = 1'b0;
        req_i = '0;
        mem_r_valid_i = 1'b1;
        #3;
        chk("post_rst_rvalid", r_valid_o, 3'b010);
        tick();
        mem_r_valid_i = 1'b0;
        tick();

        // Randomized traffic; the compare process does the checking
        pending  = 0;
        last_gnt = '0;
        repeat (2000) begin
            for (int i = 0; i < N; i++) begin
                if (req_i[i] && last_gnt[i]) begin
                    req_i[i] = 1'b0;
                end else if (!req_i[i] && $urandom_range(0, 2) == 0) begin
                    set_pl(i, $urandom, 1'($urandom), {$urandom, $urandom}, 8'($urandom));
                    req_i[i] = 1'b1;
                end else if (req_i[i] && $urandom_range(0, 31) == 0) begin
                    req_i[i] = 1'b0;
                end
            end
            mem_gnt_i     = 1'($urandom);
            mem_r_rdata_i = {$urandom, $urandom};
            mem_r_valid_i = 1'b0;
            if (mem_req_o && mem_gnt_i) begin
                mem_r_valid_i = ($urandom_range(0, 3) == 0);
                pending = !mem_r_valid_i;
            end else if (pending) begin
                mem_r_valid_i = ($urandom_range(0, 1) == 0);
                if (mem_r_valid_i) pending = 0;
            end else if (!busy_o) begin
                mem_r_valid_i = ($urandom_range(0, 7) == 0);
            end
            #3;
            last_gnt = gnt_o;
            tick();
        end

        req_i = '0;
        mem_gnt_i = 1'b0;
        mem_r_valid_i = 1'b0;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
